// File: rtl/ssram_to_ahb_if.sv
// Signal bundle between an SRAM-style client, the ssram_to_ahb initiator and the AHB-Lite bus.
// The master modport is the initiator's view; the slave modport is the client/bus side.
interface ssram_to_ahb_if #(
    parameter int AW = 12
);
    logic          sram_en;
    logic          sram_rdy;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_wb;
    logic [31:0]   sram_din;
    logic [31:0]   sram_dout;
    logic          rsp_valid;
    logic          rsp_err;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HRESP;

    modport master (
        input  sram_en, sram_we, sram_addr, sram_wb, sram_din, HREADY, HRDATA, HRESP,
        output sram_rdy, sram_dout, rsp_valid, rsp_err, HADDR, HTRANS, HSIZE, HWRITE, HWDATA
    );

    modport slave (
        output sram_en, sram_we, sram_addr, sram_wb, sram_din, HREADY, HRDATA, HRESP,
        input  sram_rdy, sram_dout, rsp_valid, rsp_err, HADDR, HTRANS, HSIZE, HWRITE, HWDATA
    );
endinterface

// File: rtl/ssram_to_ahb.sv
// AHB-Lite single-transfer initiator fed by an SRAM-style request port (one address + one data phase in flight).
// Optional macro SSRAM_TO_AHB_ERR_FLUSH_EN: on ERROR the held address-phase transfer is dropped with an error response.
module ssram_to_ahb #(
    parameter int AW = 12
) (
    input logic            HCLK,
    input logic            HRESET,
    ssram_to_ahb_if.master bus
);
    localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]    HSIZE_WORD    = 3'b010;
    localparam logic [AW-1:0] WORD_MASK     = {{(AW-2){1'b1}}, 2'b00};

    // Returns {legal, hsize, haddr[1:0]}; an all-zero read mask means a full word.
    function automatic logic [5:0] decode_mask(input logic we, input logic [3:0] wb);
        logic [5:0] d;
        case (wb)
            4'b0001: d = {1'b1, 3'b000, 2'b00};
            4'b0010: d = {1'b1, 3'b000, 2'b01};
            4'b0100: d = {1'b1, 3'b000, 2'b10};
            4'b1000: d = {1'b1, 3'b000, 2'b11};
            4'b0011: d = {1'b1, 3'b001, 2'b00};
            4'b1100: d = {1'b1, 3'b001, 2'b10};
            4'b1111: d = {1'b1, HSIZE_WORD, 2'b00};
            4'b0000: d = {~we, HSIZE_WORD, 2'b00};
            default: d = {1'b0, HSIZE_WORD, 2'b00};
        endcase
        return d;
    endfunction

    logic          ap_valid_r, ap_ill_r;
    logic [31:0]   ap_wdata_r;
    logic [AW-1:0] haddr_r;
    logic [2:0]    hsize_r;
    logic          hwrite_r;
    logic [1:0]    htrans_r;
    logic [31:0]   hwdata_r;
    logic          dp_valid_r, dp_write_r, dp_ill_r;
    logic          err_hold_r;
    logic          rsp_valid_r, rsp_err_r;
    logic [31:0]   dout_r;

    logic          ap_valid_nx_s, ap_ill_nx_s;
    logic [31:0]   ap_wdata_nx_s;
    logic [AW-1:0] haddr_nx_s;
    logic [2:0]    hsize_nx_s;
    logic          hwrite_nx_s;
    logic [1:0]    htrans_nx_s;
    logic [31:0]   hwdata_nx_s;
    logic          dp_valid_nx_s, dp_write_nx_s, dp_ill_nx_s;
    logic          rsp_valid_nx_s, rsp_err_nx_s;
    logic [31:0]   dout_nx_s;

    logic          dec_legal_s;
    logic [2:0]    dec_size_s;
    logic [1:0]    dec_low_s;
    logic          sram_rdy_s, accept_s;
    logic          dp_done_s, dp_free_s, err_start_s;
    logic          ap_go_s, ap_ill_go_s, ap_flush_s, ap_leave_s, direct_ill_s;

    assign {dec_legal_s, dec_size_s, dec_low_s} = decode_mask(bus.sram_we, bus.sram_wb);

    assign sram_rdy_s  = ~ap_valid_r | (bus.HREADY & ~err_hold_r);
    assign accept_s    = bus.sram_en & sram_rdy_s;
    // An illegal entry in the data slot never touched the bus, so it retires without HREADY.
    assign dp_done_s   = dp_valid_r & (dp_ill_r | bus.HREADY);
    assign dp_free_s   = ~dp_valid_r | dp_done_s;
    assign err_start_s = dp_valid_r & ~dp_ill_r & bus.HRESP & ~bus.HREADY;
    assign ap_go_s     = ap_valid_r & ~ap_ill_r & bus.HREADY & (htrans_r == HTRANS_NONSEQ);
    assign ap_ill_go_s = ap_valid_r & ap_ill_r & dp_free_s;
`ifdef SSRAM_TO_AHB_ERR_FLUSH_EN
    assign ap_flush_s  = ap_valid_r & ~ap_ill_r & err_hold_r & bus.HREADY;
`else
    assign ap_flush_s  = 1'b0;
`endif
    assign ap_leave_s   = ap_go_s | ap_ill_go_s | ap_flush_s;
    assign direct_ill_s = accept_s & ~dec_legal_s & ~ap_valid_r & dp_free_s;

    // Next-state for the address slot, data slot and response registers.
    always_comb begin
        ap_valid_nx_s  = ap_valid_r;
        ap_ill_nx_s    = ap_ill_r;
        ap_wdata_nx_s  = ap_wdata_r;
        haddr_nx_s     = haddr_r;
        hsize_nx_s     = hsize_r;
        hwrite_nx_s    = hwrite_r;
        htrans_nx_s    = HTRANS_IDLE;
        hwdata_nx_s    = hwdata_r;
        dp_valid_nx_s  = dp_valid_r;
        dp_write_nx_s  = dp_write_r;
        dp_ill_nx_s    = dp_ill_r;
        rsp_valid_nx_s = 1'b0;
        rsp_err_nx_s   = 1'b0;
        dout_nx_s      = dout_r;

        if (accept_s && !direct_ill_s) begin
            ap_valid_nx_s = 1'b1;
            if (dec_legal_s) begin
                ap_ill_nx_s   = 1'b0;
                ap_wdata_nx_s = bus.sram_din;
                haddr_nx_s    = (bus.sram_addr & WORD_MASK) | {{(AW-2){1'b0}}, dec_low_s};
                hsize_nx_s    = dec_size_s;
                hwrite_nx_s   = bus.sram_we;
            end else begin
                ap_ill_nx_s = 1'b1;
            end
        end else if (ap_leave_s) begin
            ap_valid_nx_s = 1'b0;
        end else begin
            ap_valid_nx_s = ap_valid_r;
        end

        if (ap_go_s) begin
            dp_valid_nx_s = 1'b1;
            dp_ill_nx_s   = 1'b0;
            dp_write_nx_s = hwrite_r;
            if (hwrite_r) begin
                hwdata_nx_s = ap_wdata_r;
            end else begin
                hwdata_nx_s = hwdata_r;
            end
        end else if (ap_ill_go_s || ap_flush_s || direct_ill_s) begin
            dp_valid_nx_s = 1'b1;
            dp_ill_nx_s   = 1'b1;
        end else if (dp_done_s) begin
            dp_valid_nx_s = 1'b0;
        end else begin
            dp_valid_nx_s = dp_valid_r;
        end

        if (dp_done_s) begin
            rsp_valid_nx_s = 1'b1;
            rsp_err_nx_s   = dp_ill_r | bus.HRESP;
            if (!dp_ill_r && !dp_write_r) begin
                dout_nx_s = bus.HRDATA;
            end else begin
                dout_nx_s = dout_r;
            end
        end else begin
            rsp_valid_nx_s = 1'b0;
        end

        // First ERROR cycle cancels the pending address phase; it is re-issued once err_hold drops.
        if (ap_valid_nx_s && !ap_ill_nx_s && !err_start_s) begin
            htrans_nx_s = HTRANS_NONSEQ;
        end else begin
            htrans_nx_s = HTRANS_IDLE;
        end
    end

    // State registers; reset abandons any transfer in flight without a response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_valid_r  <= 1'b0;
            ap_ill_r    <= 1'b0;
            ap_wdata_r  <= 32'h0000_0000;
            haddr_r     <= {AW{1'b0}};
            hsize_r     <= HSIZE_WORD;
            hwrite_r    <= 1'b0;
            htrans_r    <= HTRANS_IDLE;
            hwdata_r    <= 32'h0000_0000;
            dp_valid_r  <= 1'b0;
            dp_write_r  <= 1'b0;
            dp_ill_r    <= 1'b0;
            err_hold_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            dout_r      <= 32'h0000_0000;
        end else begin
            ap_valid_r  <= ap_valid_nx_s;
            ap_ill_r    <= ap_ill_nx_s;
            ap_wdata_r  <= ap_wdata_nx_s;
            haddr_r     <= haddr_nx_s;
            hsize_r     <= hsize_nx_s;
            hwrite_r    <= hwrite_nx_s;
            htrans_r    <= htrans_nx_s;
            hwdata_r    <= hwdata_nx_s;
            dp_valid_r  <= dp_valid_nx_s;
            dp_write_r  <= dp_write_nx_s;
            dp_ill_r    <= dp_ill_nx_s;
            err_hold_r  <= err_start_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_err_r   <= rsp_err_nx_s;
            dout_r      <= dout_nx_s;
        end
    end

    assign bus.sram_rdy  = sram_rdy_s;
    assign bus.sram_dout = dout_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.HADDR     = haddr_r;
    assign bus.HTRANS    = htrans_r;
    assign bus.HSIZE     = hsize_r;
    assign bus.HWRITE    = hwrite_r;
    assign bus.HWDATA    = hwdata_r;
endmodule

// File: tb/tb_ssram_to_ahb.sv
// Directed bench for ssram_to_ahb: single-transfer vector table plus pipelined, wait, error and reset sequences.
module tb_ssram_to_ahb;
    localparam int AW = 12;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  wb;
        logic [31:0] din;
        logic [31:0] hrdata;
        logic        legal;
        logic [11:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] dout;
    } vec_t;

    localparam int NV = 12;

    logic HCLK = 1'b0;
    logic HRESET;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [NV];

    ssram_to_ahb_if #(.AW(AW)) bus ();

    ssram_to_ahb #(.AW(AW)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.master)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic req(input logic we, input logic [11:0] addr, input logic [3:0] wb, input logic [31:0] din);
        bus.sram_en   = 1'b1;
        bus.sram_we   = we;
        bus.sram_addr = addr;
        bus.sram_wb   = wb;
        bus.sram_din  = din;
    endtask

    task automatic step();
        @(negedge HCLK);
        #1;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{1'b1, 12'h010, 4'b1111, 32'h1234_5678, 32'h0000_0000, 1'b1, 12'h010, 3'b010, 32'h0000_0000};
        vecs[1]  = '{1'b0, 12'h023, 4'b0100, 32'h0000_0000, 32'hAABB_CCDD, 1'b1, 12'h022, 3'b000, 32'hAABB_CCDD};
        vecs[2]  = '{1'b0, 12'h101, 4'b0001, 32'h0000_0000, 32'h1111_1111, 1'b1, 12'h100, 3'b000, 32'h1111_1111};
        vecs[3]  = '{1'b1, 12'h0FF, 4'b1000, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 12'h0FF, 3'b000, 32'h1111_1111};
        vecs[4]  = '{1'b0, 12'h7FE, 4'b0010, 32'h0000_0000, 32'h2222_2222, 1'b1, 12'h7FD, 3'b000, 32'h2222_2222};
        vecs[5]  = '{1'b1, 12'h031, 4'b0011, 32'hA5A5_5A5A, 32'h0000_0000, 1'b1, 12'h030, 3'b001, 32'h2222_2222};
        vecs[6]  = '{1'b0, 12'h032, 4'b1100, 32'h0000_0000, 32'h3333_4444, 1'b1, 12'h032, 3'b001, 32'h3333_4444};
        vecs[7]  = '{1'b0, 12'hFFF, 4'b0000, 32'h0000_0000, 32'h5566_7788, 1'b1, 12'hFFC, 3'b010, 32'h5566_7788};
        vecs[8]  = '{1'b1, 12'h040, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h000, 3'b000, 32'h5566_7788};
        vecs[9]  = '{1'b1, 12'h044, 4'b0101, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h000, 3'b000, 32'h5566_7788};
        vecs[10] = '{1'b0, 12'h048, 4'b0110, 32'h0000_0000, 32'h0000_0000, 1'b0, 12'h000, 3'b000, 32'h5566_7788};
        vecs[11] = '{1'b0, 12'h050, 4'b1111, 32'h0000_0000, 32'h9ABC_DEF0, 1'b1, 12'h050, 3'b010, 32'h9ABC_DEF0};

        HRESET        = 1'b1;
        bus.sram_en   = 1'b0;
        bus.sram_we   = 1'b0;
        bus.sram_addr = 12'h000;
        bus.sram_wb   = 4'b0000;
        bus.sram_din  = 32'h0000_0000;
        bus.HREADY    = 1'b1;
        bus.HRDATA    = 32'h0000_0000;
        bus.HRESP     = 1'b0;
        repeat (2) step();
        chk("rst.htrans", 32'(bus.HTRANS), 32'h0);
        chk("rst.haddr", 32'(bus.HADDR), 32'h0);
        chk("rst.hsize", 32'(bus.HSIZE), 32'h2);
        chk("rst.hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rst.hwdata", bus.HWDATA, 32'h0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst.rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rst.dout", bus.sram_dout, 32'h0);
        chk("rst.rdy", 32'(bus.sram_rdy), 32'h1);
        HRESET = 1'b0;
        step();

        // Isolated transfers: accept N, NONSEQ N+1, data N+2, response N+3 (illegal: response N+2).
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            req(v.we, v.addr, v.wb, v.din);
            bus.HRDATA = v.hrdata;
            #1;
            chk($sformatf("v%0d.rdy", i), 32'(bus.sram_rdy), 32'h1);
            step();
            bus.sram_en = 1'b0;
            chk($sformatf("v%0d.htrans", i), 32'(bus.HTRANS), v.legal ? 32'h2 : 32'h0);
            if (v.legal) begin
                chk($sformatf("v%0d.haddr", i), 32'(bus.HADDR), 32'(v.haddr));
                chk($sformatf("v%0d.hsize", i), 32'(bus.HSIZE), 32'(v.hsize));
                chk($sformatf("v%0d.hwrite", i), 32'(bus.HWRITE), 32'(v.we));
            end
            chk($sformatf("v%0d.rsp_early", i), 32'(bus.rsp_valid), 32'h0);
            step();
            if (!v.legal) begin
                chk($sformatf("v%0d.ill_valid", i), 32'(bus.rsp_valid), 32'h1);
                chk($sformatf("v%0d.ill_err", i), 32'(bus.rsp_err), 32'h1);
                chk($sformatf("v%0d.ill_dout", i), bus.sram_dout, v.dout);
            end else begin
                chk($sformatf("v%0d.rsp_n2", i), 32'(bus.rsp_valid), 32'h0);
                if (v.we) chk($sformatf("v%0d.hwdata", i), bus.HWDATA, v.din);
            end
            step();
            if (v.legal) begin
                chk($sformatf("v%0d.rsp_valid", i), 32'(bus.rsp_valid), 32'h1);
                chk($sformatf("v%0d.rsp_err", i), 32'(bus.rsp_err), 32'h0);
                chk($sformatf("v%0d.dout", i), bus.sram_dout, v.dout);
            end else begin
                chk($sformatf("v%0d.ill_strobe", i), 32'(bus.rsp_valid), 32'h0);
            end
            @(negedge HCLK);
        end

        // Four back-to-back reads, second data phase wait-stated.
        req(1'b0, 12'h000, 4'b1111, 32'h0); #1;
        chk("b2b.rdy0", 32'(bus.sram_rdy), 32'h1);
        @(negedge HCLK); bus.sram_addr = 12'h004; #1;
        chk("b2b.rdy1", 32'(bus.sram_rdy), 32'h1);
        chk("b2b.haddr0", 32'(bus.HADDR), 32'h000);
        @(negedge HCLK); bus.sram_addr = 12'h008; bus.HRDATA = 32'hD000_0000; #1;
        chk("b2b.rdy2", 32'(bus.sram_rdy), 32'h1);
        chk("b2b.haddr4", 32'(bus.HADDR), 32'h004);
        @(negedge HCLK); bus.sram_addr = 12'h00C; bus.HREADY = 1'b0; bus.HRDATA = 32'hFFFF_FFFF; #1;
        chk("b2b.rdy_wait", 32'(bus.sram_rdy), 32'h0);
        chk("b2b.haddr8a", 32'(bus.HADDR), 32'h008);
        chk("b2b.rsp0", 32'(bus.rsp_valid), 32'h1);
        chk("b2b.dout0", bus.sram_dout, 32'hD000_0000);
        @(negedge HCLK); bus.HREADY = 1'b1; bus.HRDATA = 32'hD000_0004; #1;
        chk("b2b.rdy3", 32'(bus.sram_rdy), 32'h1);
        chk("b2b.haddr8b", 32'(bus.HADDR), 32'h008);
        chk("b2b.htrans_frozen", 32'(bus.HTRANS), 32'h2);
        chk("b2b.rsp_gap", 32'(bus.rsp_valid), 32'h0);
        @(negedge HCLK); bus.sram_en = 1'b0; bus.HRDATA = 32'hD000_0008; #1;
        chk("b2b.haddrC", 32'(bus.HADDR), 32'h00C);
        chk("b2b.rsp1", 32'(bus.rsp_valid), 32'h1);
        chk("b2b.dout1", bus.sram_dout, 32'hD000_0004);
        @(negedge HCLK); bus.HRDATA = 32'hD000_000C; #1;
        chk("b2b.htrans_idle", 32'(bus.HTRANS), 32'h0);
        chk("b2b.dout2", bus.sram_dout, 32'hD000_0008);
        step();
        chk("b2b.rsp3", 32'(bus.rsp_valid), 32'h1);
        chk("b2b.dout3", bus.sram_dout, 32'hD000_000C);
        step();
        chk("b2b.rsp_end", 32'(bus.rsp_valid), 32'h0);

        // Illegal write queued behind an outstanding read keeps response order.
        @(negedge HCLK); req(1'b0, 12'h070, 4'b1111, 32'h0); bus.HRDATA = 32'h7070_7070;
        @(negedge HCLK); req(1'b1, 12'h074, 4'b0101, 32'h0); #1;
        chk("ord.rdy", 32'(bus.sram_rdy), 32'h1);
        chk("ord.htrans", 32'(bus.HTRANS), 32'h2);
        @(negedge HCLK); bus.sram_en = 1'b0; #1;
        chk("ord.no_nonseq", 32'(bus.HTRANS), 32'h0);
        step();
        chk("ord.rsp_rd", 32'(bus.rsp_valid), 32'h1);
        chk("ord.err_rd", 32'(bus.rsp_err), 32'h0);
        chk("ord.dout_rd", bus.sram_dout, 32'h7070_7070);
        step();
        chk("ord.rsp_ill", 32'(bus.rsp_valid), 32'h1);
        chk("ord.err_ill", 32'(bus.rsp_err), 32'h1);

        // ERROR on write 0x040 with read 0x044 waiting in the address phase.
        @(negedge HCLK); req(1'b1, 12'h040, 4'b1111, 32'h0BAD_F00D);
        @(negedge HCLK); req(1'b0, 12'h044, 4'b1111, 32'h0); #1;
        chk("err.haddr_w", 32'(bus.HADDR), 32'h040);
        chk("err.hwrite_w", 32'(bus.HWRITE), 32'h1);
        @(negedge HCLK); bus.sram_en = 1'b0; bus.HRESP = 1'b1; bus.HREADY = 1'b0; #1;
        chk("err.rdy_c1", 32'(bus.sram_rdy), 32'h0);
        chk("err.haddr_r", 32'(bus.HADDR), 32'h044);
        chk("err.hwdata", bus.HWDATA, 32'h0BAD_F00D);
        @(negedge HCLK); bus.HREADY = 1'b1; #1;
        chk("err.htrans_c2", 32'(bus.HTRANS), 32'h0);
        chk("err.haddr_held", 32'(bus.HADDR), 32'h044);
        chk("err.hwrite_held", 32'(bus.HWRITE), 32'h0);
        chk("err.rdy_c2", 32'(bus.sram_rdy), 32'h0);
        @(negedge HCLK); bus.HRESP = 1'b0; bus.HRDATA = 32'h4444_4444; #1;
        chk("err.rsp_w", 32'(bus.rsp_valid), 32'h1);
        chk("err.err_w", 32'(bus.rsp_err), 32'h1);
`ifdef SSRAM_TO_AHB_ERR_FLUSH_EN
        chk("err.flush_idle", 32'(bus.HTRANS), 32'h0);
        step();
        chk("err.flush_rsp", 32'(bus.rsp_valid), 32'h1);
        chk("err.flush_err", 32'(bus.rsp_err), 32'h1);
        chk("err.flush_idle2", 32'(bus.HTRANS), 32'h0);
        step();
        chk("err.flush_end", 32'(bus.rsp_valid), 32'h0);
`else
        chk("err.replay_htrans", 32'(bus.HTRANS), 32'h2);
        chk("err.replay_haddr", 32'(bus.HADDR), 32'h044);
        step();
        chk("err.replay_gap", 32'(bus.rsp_valid), 32'h0);
        step();
        chk("err.replay_rsp", 32'(bus.rsp_valid), 32'h1);
        chk("err.replay_err", 32'(bus.rsp_err), 32'h0);
        chk("err.replay_dout", bus.sram_dout, 32'h4444_4444);
`endif

        // Reset during a wait-stated data phase abandons the transfer.
        @(negedge HCLK); req(1'b0, 12'h060, 4'b1111, 32'h0);
        step(); bus.sram_en = 1'b0;
        chk("rstw.htrans", 32'(bus.HTRANS), 32'h2);
        @(negedge HCLK); bus.HREADY = 1'b0;
        @(negedge HCLK); HRESET = 1'b1; #1;
        chk("rstw.rsp_pre", 32'(bus.rsp_valid), 32'h0);
        @(negedge HCLK); HRESET = 1'b0; bus.HREADY = 1'b1; #1;
        chk("rstw.htrans_idle", 32'(bus.HTRANS), 32'h0);
        chk("rstw.haddr", 32'(bus.HADDR), 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rstw.no_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
